// File: rtl/ams_pwm_dac.sv
// Single-channel PWM DAC modulator with 16-period dither frame.
// A 24-bit setting (8-bit base duty + 16-bit dither mask) is captured into
// shadow registers only at the frame boundary, so the output never glitches
// when the register block rewrites the setting mid-frame.
module ams_pwm_dac #(
  parameter int CCRE = 156,
  parameter int DW   = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [23:0] cfg_i,
  output logic        pwm_o,
  output logic        frame_o,
  output logic [3:0]  sub_o
);

  localparam logic [DW-1:0] V_LAST = DW'(CCRE - 1);

  logic [DW-1:0] v;
  logic [3:0]    b;
  logic [DW-1:0] s_base;
  logic [15:0]   s_mask;

  logic          v_last;
  logic          boundary;
  logic [DW:0]   duty;
  logic          pwm_next;

  // Period/frame decode and duty for the current sub-period. Duty is one bit
  // wider than the base so 0xFF plus a dither bit cannot wrap; since v never
  // exceeds CCRE-1, any duty >= CCRE naturally yields a fully-on period.
  always_comb begin
    v_last   = (v == V_LAST);
    boundary = v_last && (b == 4'd15);
    duty     = {1'b0, s_base} + {{DW{1'b0}}, s_mask[b]};
    pwm_next = ({1'b0, v} < duty);
  end

  // Period counter and sub-period (dither slot) counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v <= '0;
      b <= '0;
    end else if (v_last) begin
      v <= '0;
      b <= b + 4'd1;
    end else begin
      v <= v + DW'(1);
    end
  end

  // Shadow setting capture at the frame boundary, with a one-clock marker.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s_base  <= '0;
      s_mask  <= '0;
      frame_o <= 1'b0;
    end else begin
      frame_o <= boundary;
      if (boundary) begin
        s_base <= cfg_i[23:16];
        s_mask <= cfg_i[15:0];
      end
    end
  end

  // Registered PWM output; lags the counter state by one clock.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pwm_o <= 1'b0;
    end else begin
      pwm_o <= pwm_next;
    end
  end

  assign sub_o = b;

endmodule

// File: tb/tb_ams_pwm_dac.sv
// Directed self-checking bench for ams_pwm_dac (CCRE=156, frame = 2496 clocks).
module tb_ams_pwm_dac;

  localparam int FRAME = 2496;
  localparam int PER   = 156;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [23:0] cfg_i;
  logic        pwm_o;
  logic        frame_o;
  logic [3:0]  sub_o;

  int checks   = 0;
  int failures = 0;

  int         per_hi [16];
  int         tot;
  int         fcnt;
  int         fpos;
  logic [3:0] sub_snap;
  logic       trace [1:FRAME];

  ams_pwm_dac #(.CCRE(PER), .DW(8)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .cfg_i   (cfg_i),
    .pwm_o   (pwm_o),
    .frame_o (frame_o),
    .sub_o   (sub_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Reset with a new cfg value, release between clock edges.
  task automatic do_reset(input logic [23:0] c);
    @(negedge clk_i);
    rstn_i = 1'b0;
    cfg_i  = c;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  // Run one frame worth of clocks, sampling on the falling edge. Sample i is
  // taken after the i-th rising edge of the window. Optionally change cfg_i
  // after sample chg_at (0 = no change).
  task automatic run_frame(input int chg_at, input logic [23:0] chg_val);
    for (int k = 0; k < 16; k++) per_hi[k] = 0;
    tot  = 0;
    fcnt = 0;
    fpos = 0;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      trace[i] = pwm_o;
      if (pwm_o === 1'b1) begin
        tot++;
        per_hi[(i - 1) / PER]++;
      end
      if (frame_o === 1'b1) begin
        fcnt++;
        if (fpos == 0) fpos = i;
      end
      if (i == chg_at) begin
        sub_snap = sub_o;
        cfg_i    = chg_val;
      end
    end
  endtask

  initial begin
    rstn_i   = 1'b0;
    cfg_i    = 24'h000000;
    sub_snap = 4'd0;
    #23;
    chk("reset_pwm",   32'(pwm_o),   32'd0);
    chk("reset_frame", 32'(frame_o), 32'd0);
    chk("reset_sub",   32'(sub_o),   32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Zero setting: ten silent frames, one load pulse at the end of each.
    for (int f = 0; f < 10; f++) begin
      run_frame(0, 24'h0);
      chk($sformatf("zero_tot_f%0d", f),  tot,  0);
      chk($sformatf("zero_fcnt_f%0d", f), fcnt, 1);
      chk($sformatf("zero_fpos_f%0d", f), fpos, FRAME);
    end

    // 50 % duty: 78 of 156.
    do_reset(24'h4E0000);
    run_frame(0, 24'h0);
    chk("half_first_frame_tot", tot,  0);
    chk("half_first_fpos",      fpos, FRAME);
    run_frame(0, 24'h0);
    chk("half_start_hi",  32'(trace[1]),  32'd1);
    chk("half_last_hi",   32'(trace[78]), 32'd1);
    chk("half_first_lo",  32'(trace[79]), 32'd0);
    chk("half_per0",      per_hi[0],  78);
    chk("half_per15",     per_hi[15], 78);
    chk("half_tot",       tot,        1248);
    chk("half_sub_start", 32'(sub_o), 32'd0);

    // Asynchronous reset mid-period while pwm_o is high.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    chk("arst_pre_pwm", 32'(pwm_o), 32'd1);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_pwm",   32'(pwm_o),   32'd0);
    chk("arst_frame", 32'(frame_o), 32'd0);
    chk("arst_sub",   32'(sub_o),   32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    run_frame(0, 24'h0);
    chk("arst_tot_after",  tot,  0);
    chk("arst_fcnt_after", fcnt, 1);
    chk("arst_fpos_after", fpos, FRAME);
    run_frame(0, 24'h0);
    chk("arst_reload_tot", tot, 1248);

    // Dither: base 15, mask bits 0 and 15.
    do_reset(24'h0F8001);
    run_frame(0, 24'h0);
    run_frame(0, 24'h0);
    chk("dith_per0",  per_hi[0],  16);
    chk("dith_per1",  per_hi[1],  15);
    chk("dith_per14", per_hi[14], 15);
    chk("dith_per15", per_hi[15], 16);
    chk("dith_tot",   tot,        242);

    // Saturation: base == CCRE with full mask, and base 0xFF.
    do_reset(24'h9CFFFF);
    run_frame(0, 24'h0);
    run_frame(0, 24'h0);
    chk("sat9c_first", 32'(trace[1]), 32'd1);
    chk("sat9c_tot",   tot,           FRAME);
    do_reset(24'hFF0000);
    run_frame(0, 24'h0);
    run_frame(0, 24'h0);
    chk("satff_first", 32'(trace[1]), 32'd1);
    chk("satff_tot",   tot,           FRAME);

    // Mid-frame cfg change at v=50, b=7 only takes effect next frame.
    do_reset(24'h0F0000);
    run_frame(0, 24'h0);
    run_frame(7 * PER + 50, 24'h750000);
    chk("chg_sub_at_change", 32'(sub_snap), 32'd7);
    chk("chg_per7",          per_hi[7],     15);
    chk("chg_per15",         per_hi[15],    15);
    chk("chg_old_tot",       tot,           240);
    chk("chg_fcnt",          fcnt,          1);
    chk("chg_fpos",          fpos,          FRAME);
    run_frame(0, 24'h0);
    chk("chg_new_per0", per_hi[0], 117);
    chk("chg_new_tot",  tot,       1872);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
